// File: rtl/btn_pkg.sv
// Shared definitions for the push-button event block.
// State encoding is fixed so board-level debug taps can decode it directly.
// Default timing constants assume the 100 MHz board clock.
package btn_pkg;

    localparam logic [1:0] ST_WAIT_LOW = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_PRESS    = 2'd2;
    localparam logic [1:0] ST_REPEAT   = 2'd3;

    typedef enum logic [1:0] {
        S_WAIT_LOW = ST_WAIT_LOW,
        S_IDLE     = ST_IDLE,
        S_PRESS    = ST_PRESS,
        S_REPEAT   = ST_REPEAT
    } state_t;

    // 0.5 s to long-press, then 10 Hz auto-repeat at 100 MHz.
    localparam int unsigned LONG_CYCLES_DEF   = 50_000_000;
    localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;

endpackage

// File: rtl/btn_event.sv
// Purpose: turn a debounced button level into press/release/click/long/repeat/step pulses.
// Latency: 1 clk from sampled level change to the corresponding registered pulse.
// Backpressure: none; pulses are fire-and-forget, one cycle wide.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset (clears state, counter and all outputs)
//   in         debounced button level, synchronous to clk, 1 = pressed
//   held       1 while the button is in an accepted press (PRESS or REPEAT)
//   press      pulse on the accepted rising edge
//   release_p  pulse on the falling edge after an accepted press
//              (named release_p because "release" is a reserved word)
//   click      pulse on a release before the long threshold
//   long_p     pulse when the hold reaches LONG_CYCLES
//   rpt        pulse every REPEAT_CYCLES after long_p while still held
//   step       press | long_p | rpt
module btn_event
    import btn_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int unsigned CNT_W         = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic held,
    output logic press,
    output logic release_p,
    output logic click,
    output logic long_p,
    output logic rpt,
    output logic step
);

    // Counter holds the number of cycles elapsed since the last pulse
    // (press, long_p or rpt); the terminal value fires the next pulse on
    // the following edge, so spacing is exactly LONG_CYCLES / REPEAT_CYCLES.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic held_nxt;
    logic press_nxt;
    logic release_nxt;
    logic click_nxt;
    logic long_nxt;
    logic rpt_nxt;
    logic step_nxt;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        click_nxt   = 1'b0;
        long_nxt    = 1'b0;
        rpt_nxt     = 1'b0;

        case (state)
            // A button held through reset must be seen low before it can
            // produce a press.
            S_WAIT_LOW: begin
                if (!in) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (in) begin
                    state_nxt = S_PRESS;
                    press_nxt = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            // Release is checked first so it wins over a threshold hit in
            // the same cycle.
            S_PRESS: begin
                if (!in) begin
                    state_nxt   = S_IDLE;
                    release_nxt = 1'b1;
                    click_nxt   = 1'b1;
                    cnt_nxt     = '0;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = S_REPEAT;
                    long_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_REPEAT: begin
                if (!in) begin
                    state_nxt   = S_IDLE;
                    release_nxt = 1'b1;
                    cnt_nxt     = '0;
                end else if (cnt == REPEAT_LAST) begin
                    rpt_nxt = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_WAIT_LOW;
                cnt_nxt   = '0;
            end
        endcase

        held_nxt = (state_nxt == S_PRESS) || (state_nxt == S_REPEAT);
        step_nxt = press_nxt | long_nxt | rpt_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_WAIT_LOW;
            cnt       <= '0;
            held      <= 1'b0;
            press     <= 1'b0;
            release_p <= 1'b0;
            click     <= 1'b0;
            long_p    <= 1'b0;
            rpt       <= 1'b0;
            step      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            held      <= held_nxt;
            press     <= press_nxt;
            release_p <= release_nxt;
            click     <= click_nxt;
            long_p    <= long_nxt;
            rpt       <= rpt_nxt;
            step      <= step_nxt;
        end
    end

endmodule
